imem_fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer between the core's decode stage and INST_MEM.
- INST_MEM is a synchronous-read ROM: the word for the ADDR presented in cycle N appears on INST in cycle N+1, with no enable and no stall input.
- This block owns the PC. It issues fetch addresses, tracks the one-cycle in-flight read, and buffers returned words in a 2-entry skid queue under a valid/ready handshake to decode.
- It also applies branch redirects with flush, and halts on an all-zero word, which is the ROM's value outside the loaded program.

---
 rtl/imem_fetch_ctrl_if.sv | 34 +++
 rtl/imem_fetch_ctrl.sv | 115 +++++++++++
 tb/tb_imem_fetch_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bus: INST_MEM address/data plus the decode
// valid/ready handshake and the branch redirect request.
interface imem_fetch_ctrl_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_addr,
        input  imem_inst,
        output if_valid,
        input  if_ready,
        output if_pc,
        output if_inst,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_addr,
        output imem_inst,
        input  if_valid,
        output if_ready,
        input  if_pc,
        input  if_inst,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, tracks one in-flight ROM read
// and buffers returned words in a 2-entry skid queue toward decode.
module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic clk_50,
    input  logic rst_n,
    input  logic fetch_en,
    output logic halted,
    imem_fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic [31:0] skid_pc   [2];
    logic [31:0] skid_inst [2];
    logic        head;
    logic [1:0]  count;

    logic        redir;
    logic        pop;
    logic        ret;
    logic        ret_zero;
    logic        push;
    logic [1:0]  cnt_eff;
    logic [2:0]  occ;
    logic        issue;

    assign redir = bus.redirect_valid && (state != IDLE);

    assign bus.imem_addr = bus.redirect_valid ? bus.redirect_pc : pc;
    assign bus.if_valid  = (count != 2'd0) && !bus.redirect_valid;
    assign bus.if_pc     = skid_pc[head];
    assign bus.if_inst   = skid_inst[head];

    assign pop      = bus.if_valid && bus.if_ready;
    assign ret      = inflight && !redir;
    assign ret_zero = ret && (state == RUN) && (bus.imem_inst == 32'd0);
    assign push     = ret && !ret_zero;

    // Credit check sees the slots left after this cycle's pop/flush,
    // counting the word returning now as already occupying one.
    assign cnt_eff = redir ? 2'd0 : count - {1'b0, pop};
    assign occ     = {1'b0, cnt_eff} + {2'b00, ret};
    assign issue   = redir ||
                     ((state == RUN) && fetch_en && !ret_zero && (occ < 3'd2));

    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            halted      <= 1'b0;
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            head        <= 1'b0;
            count       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                skid_pc[i]   <= '0;
                skid_inst[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (fetch_en) state <= RUN;
                end
                RUN: begin
                    if (ret_zero) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (redir) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    halted <= 1'b0;
                end
            endcase

            inflight <= issue;
            if (issue) begin
                inflight_pc <= bus.imem_addr;
                pc          <= bus.imem_addr + PC_STEP;
            end

            if (redir) begin
                head  <= 1'b0;
                count <= 2'd0;
            end else begin
                // Tail slot is head+count mod 2; with a full queue and a
                // pop this reuses the slot being vacated.
                if (push) begin
                    skid_pc[head ^ count[0]]   <= inflight_pc;
                    skid_inst[head ^ count[0]] <= bus.imem_inst;
                end
                if (pop) head <= ~head;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed vector table plus
// hand sequences for stall, redirect, halt, async reset and random traffic.
module tb_imem_fetch_ctrl;

    logic clk_50 = 1'b0;
    logic rst_n  = 1'b0;
    logic fetch_en = 1'b0;
    logic halted;

    imem_fetch_ctrl_if bus ();

    imem_fetch_ctrl #(
        .RESET_PC(32'd0),
        .PC_STEP (32'd4)
    ) dut (
        .clk_50  (clk_50),
        .rst_n   (rst_n),
        .fetch_en(fetch_en),
        .halted  (halted),
        .bus     (bus.master)
    );

    always #5 clk_50 = ~clk_50;

    logic [31:0] rom [64];

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a >= 32'd236) return 32'd0;
        return rom[a[7:2]];
    endfunction

    always @(posedge clk_50) bus.imem_inst <= rom_word(bus.imem_addr);

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    // Scoreboard: expected delivery order follows PC_STEP, restarting
    // at each redirect target and at reset.
    logic        live = 1'b0;
    logic [31:0] exp_pc = 32'd0;
    logic [31:0] last_pc = 32'd0;
    int          pops = 0;

    always @(negedge clk_50) begin
        if (!rst_n) begin
            exp_pc = 32'd0;
        end else begin
            chk("count_le2", 32'(dut.count <= 2'd2), 32'd1);
            if (bus.redirect_valid && live) begin
                exp_pc = bus.redirect_pc;
            end else if (bus.if_valid && bus.if_ready) begin
                chk("seq_pc", bus.if_pc, exp_pc);
                chk("seq_inst", bus.if_inst, rom_word(bus.if_pc));
                last_pc = bus.if_pc;
                exp_pc  = exp_pc + 32'd4;
                pops++;
            end
        end
    end

    typedef struct {
        logic        ready;
        logic        vld;
        logic [31:0] pc;
        logic [31:0] addr;
    } vec_t;

    vec_t vt [16];

    task automatic cyc();
        @(posedge clk_50);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit hit;
        int p0;
        for (int i = 0; i < 64; i++)
            rom[i] = (i >= 59) ? 32'd0 : (32'h13 | (32'(i) << 7));
        rom[5]  = 32'hfec10113;
        rom[17] = 32'h00300693;

        vt[0]  = '{1'b1, 1'b0, 32'd0,  32'd0};
        vt[1]  = '{1'b1, 1'b0, 32'd0,  32'd4};
        vt[2]  = '{1'b1, 1'b1, 32'd0,  32'd8};
        vt[3]  = '{1'b1, 1'b1, 32'd4,  32'd12};
        vt[4]  = '{1'b1, 1'b1, 32'd8,  32'd16};
        vt[5]  = '{1'b1, 1'b1, 32'd12, 32'd20};
        vt[6]  = '{1'b1, 1'b1, 32'd16, 32'd24};
        vt[7]  = '{1'b0, 1'b1, 32'd20, 32'd28};
        vt[8]  = '{1'b0, 1'b1, 32'd20, 32'd28};
        vt[9]  = '{1'b0, 1'b1, 32'd20, 32'd28};
        vt[10] = '{1'b0, 1'b1, 32'd20, 32'd28};
        vt[11] = '{1'b0, 1'b1, 32'd20, 32'd28};
        vt[12] = '{1'b1, 1'b1, 32'd20, 32'd28};
        vt[13] = '{1'b1, 1'b1, 32'd24, 32'd32};
        vt[14] = '{1'b1, 1'b1, 32'd28, 32'd36};
        vt[15] = '{1'b1, 1'b1, 32'd32, 32'd40};

        bus.if_ready       = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;

        #2;
        chk("rst_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_pc", bus.if_pc, 32'd0);
        chk("rst_inst", bus.if_inst, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_addr", bus.imem_addr, 32'd0);

        cyc();
        rst_n = 1'b1;

        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd100;
        @(negedge clk_50);
        chk("idle_redir_addr", bus.imem_addr, 32'd100);
        chk("idle_redir_valid", 32'(bus.if_valid), 32'd0);
        cyc();
        bus.redirect_valid = 1'b0;
        @(negedge clk_50);
        chk("idle_redir_ignored", bus.imem_addr, 32'd0);
        chk("idle_halted", 32'(halted), 32'd0);

        fetch_en = 1'b1;
        live     = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            bus.if_ready = vt[i].ready;
            @(negedge clk_50);
            chk($sformatf("vec%0d_valid", i), 32'(bus.if_valid),
                32'(vt[i].vld));
            chk($sformatf("vec%0d_addr", i), bus.imem_addr, vt[i].addr);
            if (vt[i].vld) begin
                chk($sformatf("vec%0d_pc", i), bus.if_pc, vt[i].pc);
                chk($sformatf("vec%0d_inst", i), bus.if_inst,
                    rom_word(vt[i].pc));
            end
        end
        chk("stall_inst", rom_word(32'd20), 32'hfec10113);

        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            cyc();
            @(negedge clk_50);
            hit = bus.if_valid && (bus.if_pc == 32'd156);
        end
        chk("reach_156", 32'(hit), 32'd1);
        cyc();
        bus.if_ready = 1'b0;
        @(negedge clk_50);
        chk("buf_head160", bus.if_pc, 32'd160);
        cyc();
        @(negedge clk_50);
        chk("buf_full_pc", bus.if_pc, 32'd160);
        chk("buf_full_addr", bus.imem_addr, 32'd168);
        cyc();
        bus.if_ready       = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd68;
        @(negedge clk_50);
        chk("redir_valid", 32'(bus.if_valid), 32'd0);
        chk("redir_addr", bus.imem_addr, 32'd68);
        cyc();
        bus.redirect_valid = 1'b0;
        @(negedge clk_50);
        chk("redir_bubble", 32'(bus.if_valid), 32'd0);
        chk("redir_next_addr", bus.imem_addr, 32'd72);
        cyc();
        @(negedge clk_50);
        chk("redir_tgt_valid", 32'(bus.if_valid), 32'd1);
        chk("redir_tgt_pc", bus.if_pc, 32'd68);
        chk("redir_tgt_inst", bus.if_inst, 32'h00300693);

        hit = 1'b0;
        for (int i = 0; i < 100 && !hit; i++) begin
            cyc();
            @(negedge clk_50);
            hit = halted;
        end
        chk("halt_reached", 32'(hit), 32'd1);
        chk("halt_valid", 32'(bus.if_valid), 32'd0);
        chk("halt_addr", bus.imem_addr, 32'd240);
        chk("halt_last_pc", last_pc, 32'd232);
        cyc();
        @(negedge clk_50);
        chk("halt_hold", 32'(halted), 32'd1);
        chk("halt_hold_valid", 32'(bus.if_valid), 32'd0);
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'd0;
        @(negedge clk_50);
        chk("resume_addr", bus.imem_addr, 32'd0);
        cyc();
        bus.redirect_valid = 1'b0;
        @(negedge clk_50);
        chk("resume_halted", 32'(halted), 32'd0);
        cyc();
        @(negedge clk_50);
        chk("resume_valid", 32'(bus.if_valid), 32'd1);
        chk("resume_pc", bus.if_pc, 32'd0);

        cyc();
        bus.if_ready = 1'b0;
        cyc();
        cyc();
        @(negedge clk_50);
        chk("pre_rst_valid", 32'(bus.if_valid), 32'd1);
        @(posedge clk_50);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.if_valid), 32'd0);
        chk("async_rst_pc", bus.if_pc, 32'd0);
        chk("async_rst_inst", bus.if_inst, 32'd0);
        chk("async_rst_halted", 32'(halted), 32'd0);
        chk("async_rst_addr", bus.imem_addr, 32'd0);
        cyc();
        rst_n        = 1'b1;
        bus.if_ready = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 10 && !hit; i++) begin
            cyc();
            @(negedge clk_50);
            hit = bus.if_valid;
        end
        chk("restart_valid", 32'(hit), 32'd1);
        chk("restart_pc", bus.if_pc, 32'd0);
        chk("restart_inst", bus.if_inst, 32'h00000013);

        p0 = pops;
        for (int i = 0; i < 300; i++) begin
            cyc();
            bus.if_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 32'($urandom_range(0, 30)) * 32'd4;
            end else begin
                bus.redirect_valid = 1'b0;
            end
            @(negedge clk_50);
        end
        bus.redirect_valid = 1'b0;
        chk("rand_progress", 32'((pops - p0) > 50), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
